// File: rtl/bit4_minus_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding, default width and counter-width helper.
package bit4_minus_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ceil(log2(n)), never below 1 so a counter always has a bit
  function automatic int clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 32; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/bit4_minus_serial_full_sub1.sv
// Combinational 1-bit full subtractor.
// Ports: a - b - bin -> difference d, borrow out bout.
module full_sub1 (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bit4_minus_serial.sv
// Bit-serial WIDTH-bit subtractor D = A - B, LSB first, one bit per clock.
// Ports: in_valid/in_ready + inA/inB in; out_valid/out_ready + outD/Bout/Vout out.
module bit4_minus_serial
  import bit4_minus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outD,
  output logic             Bout,
  output logic             Vout
);

  localparam int CW = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_n;

  logic [WIDTH-1:0] ra, rb;
  logic [CW-1:0]    cnt;
  logic             borrow, sa, sb;
  logic             d, br, last;

  full_sub1 u_fs (
    .a    (ra[0]),
    .b    (rb[0]),
    .bin  (borrow),
    .d    (d),
    .bout (br)
  );

  assign last      = (cnt == LAST);
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = RUN;
      RUN:     if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra     <= '0;
      rb     <= '0;
      outD   <= '0;
      cnt    <= '0;
      borrow <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      Bout   <= 1'b0;
      Vout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ra     <= inA;
            rb     <= inB;
            sa     <= inA[WIDTH-1];
            sb     <= inB[WIDTH-1];
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          ra     <= ra >> 1;
          rb     <= rb >> 1;
          outD   <= {d, outD[WIDTH-1:1]};
          borrow <= br;
          cnt    <= cnt + 1'b1;
          // final bit is the result sign, so overflow is decided here
          if (last) begin
            Bout <= br;
            Vout <= (sa ^ sb) & (d ^ sa);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bit4_minus_serial.sv
// Directed self-checking bench for bit4_minus_serial.
// Drives on negedge, samples on negedge after each active edge.
module tb_bit4_minus_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic       out_valid, out_ready;
  logic [3:0] inA, inB, outD;
  logic       Bout, Vout;

  int total = 0;
  int bad   = 0;

  bit4_minus_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .inA       (inA),
    .inB       (inB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .outD      (outD),
    .Bout      (Bout),
    .Vout      (Vout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // accept one operand pair, wait (bounded) for out_valid
  task automatic start_op(input logic [3:0] a, input logic [3:0] b,
                          output int lat);
    @(negedge clk);
    inA = a;
    inB = b;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    inA = 4'hx;
    inB = 4'hx;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  int lat;
  logic [3:0] ed, s;
  logic eb, ev;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    inA = 4'h0;
    inB = 4'h0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outD", 32'(outD), 32'd0);
    chk("rst_Bout", 32'(Bout), 32'd0);
    chk("rst_Vout", 32'(Vout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // out_ready while idle must do nothing
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_ready_ign", 32'(in_ready), 32'd1);

    // 5-3
    start_op(4'd5, 4'd3, lat);
    chk("5m3_lat", 32'(lat), 32'd4);
    chk("5m3_D", 32'(outD), 32'd2);
    chk("5m3_B", 32'(Bout), 32'd0);
    chk("5m3_V", 32'(Vout), 32'd0);
    chk("5m3_in_ready", 32'(in_ready), 32'd0);
    finish_op();
    chk("5m3_back_idle", 32'(in_ready), 32'd1);
    chk("5m3_hold_D", 32'(outD), 32'd2);

    // 3-5
    start_op(4'd3, 4'd5, lat);
    chk("3m5_lat", 32'(lat), 32'd4);
    chk("3m5_D", 32'(outD), 32'hE);
    chk("3m5_B", 32'(Bout), 32'd1);
    chk("3m5_V", 32'(Vout), 32'd0);
    finish_op();

    // -8-1 overflow
    start_op(4'h8, 4'h1, lat);
    chk("8m1_D", 32'(outD), 32'h7);
    chk("8m1_B", 32'(Bout), 32'd0);
    chk("8m1_V", 32'(Vout), 32'd1);
    finish_op();

    // F-F
    start_op(4'hF, 4'hF, lat);
    chk("FmF_D", 32'(outD), 32'h0);
    chk("FmF_B", 32'(Bout), 32'd0);
    chk("FmF_V", 32'(Vout), 32'd0);
    finish_op();

    // 0-F
    start_op(4'h0, 4'hF, lat);
    chk("0mF_D", 32'(outD), 32'h1);
    chk("0mF_B", 32'(Bout), 32'd1);
    chk("0mF_V", 32'(Vout), 32'd0);
    finish_op();

    // backpressure with ignored in_valid pulses
    start_op(4'd5, 4'd3, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      inA = 4'hC;
      inB = 4'h1;
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_D", 32'(outD), 32'd2);
      chk("bp_B", 32'(Bout), 32'd0);
      chk("bp_V", 32'(Vout), 32'd0);
    end
    in_valid = 1'b0;
    finish_op();
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // reset during RUN cycle 2
    @(negedge clk);
    inA = 4'd9;
    inB = 4'd1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_outD", 32'(outD), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(4'd6, 4'd2, lat);
    chk("6m2_lat", 32'(lat), 32'd4);
    chk("6m2_D", 32'(outD), 32'd4);
    chk("6m2_B", 32'(Bout), 32'd0);
    chk("6m2_V", 32'(Vout), 32'd0);
    finish_op();

    // exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        ed = 4'(a - b);
        eb = (a < b);
        ev = (4'(a) >> 3 != 4'(b) >> 3) && (ed[3] != 4'(a) >> 3);
        start_op(4'(a), 4'(b), lat);
        chk($sformatf("sw_D_%0d_%0d", a, b), 32'(outD), 32'(ed));
        chk($sformatf("sw_B_%0d_%0d", a, b), 32'(Bout), 32'(eb));
        chk($sformatf("sw_V_%0d_%0d", a, b), 32'(Vout), 32'(ev));
        finish_op();
      end
    end

    // round trip (A+B)-B == A
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        s = 4'(a + b);
        start_op(s, 4'(b), lat);
        chk($sformatf("rt_%0d_%0d", a, b), 32'(outD), 32'(a));
        finish_op();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
